// File: rtl/common_pkg.sv
// Shared pipeline types used across the core's memory-side blocks.
package common_pkg;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2
  } msize_t;

endpackage

// File: rtl/mem_dbus_ctrl_pkg.sv
// Types and constants for the memory-stage data-bus controller.
// Segment constants are used by the MEM_DBUS_KSEG_EN address mapping.
package mem_dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_REQ,
    DB_WAIT,
    DB_DONE
  } dbus_state_t;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

endpackage

// File: rtl/mem_dbus_ctrl_addr_map.sv
// Combinational kernel-segment mapping: kseg0/kseg1 fold onto physical
// address 0, every other segment passes through. Used under MEM_DBUS_KSEG_EN.
module dbus_addr_map
  import mem_dbus_ctrl_pkg::*;
(
  input  logic [31:0] addr,
  output logic [31:0] mapped
);

  logic is_kseg;

  assign is_kseg = (addr[31:29] == KSEG0) || (addr[31:29] == KSEG1);
  assign mapped  = is_kseg ? {3'b000, addr[28:0]} : addr;

endmodule

// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus controller: one addr_ok/data_ok transaction per request.
// Define MEM_DBUS_KSEG_EN to fold kseg0/kseg1 addresses onto physical space.
module mem_dbus_ctrl
  import common_pkg::*;
  import mem_dbus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_vreq,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_strobe,
  input  msize_t      m_size,
  input  logic        m_advance,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output msize_t      dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  dbus_state_t state;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strobe;
  msize_t      req_size;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= DB_IDLE;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_strobe <= '0;
      req_size   <= MSIZE_B;
      mem_rdata  <= '0;
      dreq_valid <= 1'b0;
    end else begin
      case (state)
        DB_IDLE: begin
          if (m_vreq) begin
            req_addr   <= m_addr;
            req_wdata  <= m_wdata;
            req_strobe <= m_strobe;
            req_size   <= m_size;
            dreq_valid <= 1'b1;
            state      <= DB_REQ;
          end
        end
        DB_REQ: begin
          if (dresp_addr_ok) begin
            dreq_valid <= 1'b0;
            if (dresp_data_ok) begin
              mem_rdata <= dresp_data;
              state     <= DB_DONE;
            end else begin
              state <= DB_WAIT;
            end
          end
        end
        DB_WAIT: begin
          if (dresp_data_ok) begin
            mem_rdata <= dresp_data;
            state     <= DB_DONE;
          end
        end
        DB_DONE: begin
          // Holding here until M advances keeps a back-end stall from replaying a store.
          if (m_advance) begin
            state <= DB_IDLE;
          end
        end
        default: begin
          state      <= DB_IDLE;
          dreq_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_stall = ((state == DB_IDLE) && m_vreq) || (state == DB_REQ) || (state == DB_WAIT);

  assign dreq_data   = req_wdata;
  assign dreq_strobe = req_strobe;
  assign dreq_size   = req_size;

`ifdef MEM_DBUS_KSEG_EN
  dbus_addr_map u_addr_map (
    .addr   (req_addr),
    .mapped (dreq_addr)
  );
`else
  assign dreq_addr = req_addr;
`endif

  // A response with nothing outstanding means the bus has lost track of the protocol.
  property p_no_stray_data_ok;
    @(posedge clk) disable iff (!resetn)
      !(dresp_data_ok && ((state == DB_IDLE) || (state == DB_DONE)));
  endproperty
  assert property (p_no_stray_data_ok);

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Bench for mem_dbus_ctrl: scripted bus timelines per transaction with
// randomized payloads/delays, checked every cycle against expected outputs.
module tb_mem_dbus_ctrl;
  import common_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m_vreq = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_strobe = '0;
  msize_t      m_size = MSIZE_B;
  logic        m_advance = 1'b0;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  msize_t      dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;

  always #5 clk = ~clk;

  mem_dbus_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .m_vreq        (m_vreq),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_strobe      (m_strobe),
    .m_size        (m_size),
    .m_advance     (m_advance),
    .mem_stall     (mem_stall),
    .mem_rdata     (mem_rdata),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  // Expected outputs for the current cycle, set by the stimulus alongside the inputs.
  logic        e_en = 1'b0;
  logic        e_stall, e_valid, e_fields, e_rdata_chk;
  logic [31:0] e_addr, e_data, e_rdata;
  logic [3:0]  e_strobe;
  msize_t      e_size;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int valid_cnt = 0;
  logic [31:0] seen_addr = '0;
  logic [31:0] seen_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_map(input logic [31:0] a);
`ifdef MEM_DBUS_KSEG_EN
    int seg;
    seg = int'(a >> 29);
    if (seg == 4 || seg == 5) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  always @(negedge clk) begin
    if (e_en) begin
      chk("mem_stall", 32'(mem_stall), 32'(e_stall));
      chk("dreq_valid", 32'(dreq_valid), 32'(e_valid));
      if (e_fields) begin
        chk("dreq_addr", dreq_addr, e_addr);
        chk("dreq_data", dreq_data, e_data);
        chk("dreq_strobe", 32'(dreq_strobe), 32'(e_strobe));
        chk("dreq_size", 32'(dreq_size), 32'(e_size));
      end
      if (e_rdata_chk) chk("mem_rdata", mem_rdata, e_rdata);
      if (mem_stall) stall_cnt++;
      if (dreq_valid) begin
        valid_cnt++;
        seen_addr = dreq_addr;
      end
      seen_rdata = mem_rdata;
    end
  end

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      m_vreq = 1'b0; m_addr = $urandom; m_advance = 1'($urandom);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
      e_stall = 1'b0; e_valid = 1'b0; e_fields = 1'b0; e_rdata_chk = 1'b0;
      cyc();
    end
  endtask

  // One request: aw REQ cycles without addr_ok, then dw WAIT cycles (0 = data_ok with addr_ok),
  // then hold DONE cycles without m_advance. abort resets the design during the first WAIT cycle.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strobe,
                     input msize_t size, input int aw, input int dw, input int hold,
                     input logic [31:0] rdata, input bit vreq_in_done, input bit abort);
    m_vreq = 1'b1; m_addr = addr; m_wdata = wdata; m_strobe = strobe; m_size = size;
    m_advance = 1'($urandom);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
    e_stall = 1'b1; e_valid = 1'b0; e_fields = 1'b0; e_rdata_chk = 1'b0;
    cyc();
    for (int k = 0; k <= aw; k++) begin
      m_vreq = 1'($urandom); m_addr = $urandom; m_wdata = $urandom; m_strobe = 4'($urandom);
      m_size = msize_t'($urandom_range(0, 2)); m_advance = 1'($urandom);
      dresp_addr_ok = (k == aw);
      dresp_data_ok = (k == aw) && (dw == 0);
      dresp_data = dresp_data_ok ? rdata : $urandom;
      e_stall = 1'b1; e_valid = 1'b1; e_fields = 1'b1;
      e_addr = exp_map(addr); e_data = wdata; e_strobe = strobe; e_size = size;
      cyc();
    end
    for (int j = 1; j <= dw; j++) begin
      m_vreq = 1'($urandom); m_addr = $urandom; m_advance = 1'($urandom);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = (j == dw) && !abort;
      dresp_data = dresp_data_ok ? rdata : $urandom;
      e_stall = 1'b1; e_valid = 1'b0; e_fields = 1'b0;
      cyc();
      if (abort) begin
        // Late response arriving under reset must leave no trace.
        resetn = 1'b0; dresp_data_ok = 1'b1; dresp_data = rdata; e_en = 1'b0;
        cyc();
        resetn = 1'b1; dresp_data_ok = 1'b0; m_vreq = 1'b0; e_en = 1'b1;
        e_stall = 1'b0; e_valid = 1'b0; e_fields = 1'b1;
        e_addr = '0; e_data = '0; e_strobe = '0; e_size = MSIZE_B;
        e_rdata_chk = 1'b1; e_rdata = '0;
        cyc();
        return;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      m_vreq = vreq_in_done ? 1'b1 : 1'($urandom); m_addr = $urandom;
      m_advance = (h == hold);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
      e_stall = 1'b0; e_valid = 1'b0; e_fields = 1'b0; e_rdata_chk = 1'b1; e_rdata = rdata;
      cyc();
    end
    e_rdata_chk = 1'b0;
  endtask

  initial begin
    e_stall = 1'b0; e_valid = 1'b0; e_fields = 1'b0; e_rdata_chk = 1'b0;
    e_addr = '0; e_data = '0; e_strobe = '0; e_size = MSIZE_B; e_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    e_en = 1'b1; e_fields = 1'b1; e_rdata_chk = 1'b1;
    cyc();
    $display("txn reset: outputs idle and zero");

    // 1. Load with same-cycle addr_ok/data_ok.
    stall_cnt = 0; valid_cnt = 0;
    txn(32'h0000_1004, 32'h0, 4'b0000, MSIZE_W, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("t1_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("t1_valid_cycles", 32'(valid_cnt), 32'd1);
    chk("t1_rdata", seen_rdata, 32'hDEAD_BEEF);
    $display("txn t1: LW 0x00001004 rdata 0xdeadbeef");

    // 2. Byte store, data_ok three cycles after addr_ok.
    stall_cnt = 0; valid_cnt = 0;
    txn(32'h0000_1003, 32'h5A5A_5A5A, 4'b1000, MSIZE_B, 0, 3, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
    chk("t2_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("t2_valid_cycles", 32'(valid_cnt), 32'd1);
    $display("txn t2: SB 0x00001003 strobe 1000");

    // 3. addr_ok withheld four cycles.
    stall_cnt = 0; valid_cnt = 0;
    idle_cycles(1);
    txn(32'h0000_2000, 32'h1234_5678, 4'b1111, MSIZE_W, 4, 0, 0, 32'hCAFE_0001, 1'b0, 1'b0);
    chk("t3_stall_cycles", 32'(stall_cnt), 32'd6);
    chk("t3_valid_cycles", 32'(valid_cnt), 32'd5);
    $display("txn t3: SW 0x00002000 addr_ok delayed 4");

    // 4. DONE held three cycles with m_vreq high: no reissue.
    stall_cnt = 0; valid_cnt = 0;
    txn(32'h0000_3000, 32'hAAAA_5555, 4'b0011, MSIZE_H, 1, 1, 3, 32'h7777_1111, 1'b1, 1'b0);
    chk("t4_valid_cycles", 32'(valid_cnt), 32'd2);
    $display("txn t4: SH 0x00003000 done held 3");

    // 5. Reset while waiting for data_ok.
    txn(32'h0000_4000, 32'h0, 4'b0000, MSIZE_W, 0, 2, 0, 32'h9999_9999, 1'b0, 1'b1);
    chk("t5_rdata_after_reset", seen_rdata, 32'h0);
    $display("txn t5: reset in WAIT");

    // 6. kseg1 address.
    txn(32'hBFC0_0010, 32'h0, 4'b0000, MSIZE_W, 0, 0, 0, 32'h0102_0304, 1'b0, 1'b0);
`ifdef MEM_DBUS_KSEG_EN
    chk("t6_dreq_addr", seen_addr, 32'h1FC0_0010);
`else
    chk("t6_dreq_addr", seen_addr, 32'hBFC0_0010);
`endif
    $display("txn t6: LW 0xbfc00010 bus addr 0x%08h", seen_addr);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, w, r;
      logic [3:0]  s;
      int aw, dw, hold;
      a = $urandom; w = $urandom; r = $urandom; s = 4'($urandom);
      aw = $urandom_range(0, 3); dw = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      idle_cycles($urandom_range(0, 2));
      txn(a, w, s, msize_t'($urandom_range(0, 2)), aw, dw, hold, r, 1'($urandom), 1'b0);
      $display("txn r%0d: addr 0x%08h strobe %b aw %0d dw %0d hold %0d rdata 0x%08h",
               n, a, s, aw, dw, hold, r);
    end

    idle_cycles(2);
    e_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
